// File: rtl/c17_chk_pkg.sv
// Shared types, MISR constants and the c17 golden model for the response checker.
package c17_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // v = {N1,N2,N3,N6,N7}; returns {g22, g23}
  function automatic logic [1:0] c17_golden(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

endpackage

// File: rtl/c17_chk_delay.sv
// Valid-tagged shift line: data emerges DEPTH edges after entry, one entry per cycle.
// o_pend flags valid entries that will still be held after the next shift.
module c17_chk_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic         o_pend
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_dat [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];

  // The last stage is excluded: it is consumed on the coming edge.
  always_comb begin
    o_pend = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) o_pend = o_pend | r_vld[i];
  end

endmodule

// File: rtl/c17_resp_checker.sv
// Golden-compare stage for a pipelined c17: aligns expected N22/N23, counts mismatches,
// and (with C17_CHK_MISR_EN defined) compacts observed responses into a 16-bit MISR.
module c17_resp_checker #(
  parameter int LAT22 = 3,
  parameter int LAT23 = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             vec_valid,
  input  logic [4:0]       vec_in,
  input  logic             dut_n22,
  input  logic             dut_n23,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      signature
);

  import c17_chk_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_num, r_acc, r_err, w_err_nxt;
  logic             r_pass;
  logic             w_tag, w_start;
  logic [1:0]       w_gold;
  logic             w_t22, w_g22, w_p22, w_t23, w_g23, w_p23;
  logic             w_mis22, w_mis23;
  logic [CNT_W:0]   w_sum;

  assign w_start = (r_state == IDLE) && start;
  assign w_tag   = vec_valid && (r_state == RUN) && (r_acc < r_num);
  assign w_gold  = c17_golden(vec_in);

  c17_chk_delay #(.DEPTH(LAT22), .W(1)) u_dly22 (
    .clk(clk), .rst_n(rst_n), .i_vld(w_tag), .i_dat(w_gold[1]),
    .o_vld(w_t22), .o_dat(w_g22), .o_pend(w_p22)
  );

  c17_chk_delay #(.DEPTH(LAT23), .W(1)) u_dly23 (
    .clk(clk), .rst_n(rst_n), .i_vld(w_tag), .i_dat(w_gold[0]),
    .o_vld(w_t23), .o_dat(w_g23), .o_pend(w_p23)
  );

  assign w_mis22 = w_t22 & (w_g22 ^ dut_n22);
  assign w_mis23 = w_t23 & (w_g23 ^ dut_n23);
  assign w_sum   = {1'b0, r_err} + (CNT_W+1)'(w_mis22) + (CNT_W+1)'(w_mis23);

  always_comb begin
    w_err_nxt = r_err;
    if (w_start)          w_err_nxt = '0;
    else if (w_sum[CNT_W]) w_err_nxt = '1;
    else                  w_err_nxt = w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (num_patterns == '0) ? DONE : RUN;
      RUN:     if (w_tag && ((r_acc + CNT_W'(1)) == r_num)) w_state_nxt = DRAIN;
      DRAIN:   if (!w_p22 && !w_p23) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN) || (r_state == DRAIN);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_acc  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_start) begin
        r_num <= num_patterns;
        r_acc <= '0;
      end else if (w_tag) begin
        r_acc <= r_acc + CNT_W'(1);
      end
      r_err <= w_err_nxt;
      // Final compare lands on the same edge that enters DONE, so use the next-state count.
      if ((w_state_nxt == DONE) && (r_state != DONE)) r_pass <= (w_err_nxt == '0);
    end
  end

  assign pass      = r_pass;
  assign err_count = r_err;

`ifdef C17_CHK_MISR_EN
  logic [15:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_sig <= 16'h0000;
    else if (w_start)      r_sig <= MISR_SEED;
    else if (w_t22 | w_t23)
      r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000)
             ^ {14'b0, w_t23 & dut_n23, w_t22 & dut_n22};
  end

  assign signature = r_sig;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_c17_resp_checker.sv
// Scoreboard bench for c17_resp_checker driven by a behavioural pipelined c17 model.
module tb_c17_resp_checker;

  localparam int L22 = 3;
  localparam int L23 = 5;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, vec_valid, dut_n22, dut_n23;
  logic [CW-1:0] num_patterns;
  logic [4:0]    vec_in;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [15:0]   signature;

  always #5 clk = ~clk;

  c17_resp_checker #(.LAT22(L22), .LAT23(L23), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
    .vec_valid(vec_valid), .vec_in(vec_in), .dut_n22(dut_n22), .dut_n23(dut_n23),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .signature(signature)
  );

  function automatic logic [1:0] gold(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = v;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // Pipelined c17 stand-in, with optional output inversion for fault injection
  logic [1:0] gv;
  logic       p22 [L22];
  logic       p23 [L23];
  logic       inv22 = 1'b0, inv23 = 1'b0;
  assign gv = gold(vec_in);

  initial begin
    for (int i = 0; i < L22; i++) p22[i] = 1'b0;
    for (int i = 0; i < L23; i++) p23[i] = 1'b0;
  end

  always @(posedge clk) begin
    p22[0] <= gv[1];
    p23[0] <= gv[0];
    for (int i = 1; i < L22; i++) p22[i] <= p22[i-1];
    for (int i = 1; i < L23; i++) p23[i] <= p23[i-1];
  end

  assign dut_n22 = p22[L22-1] ^ inv22;
  assign dut_n23 = p23[L23-1] ^ inv23;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {int err; int pass; int sig;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   done_cnt = 0;
  int   busy_cyc = 0;
  int   last_sig = 0;

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_done: done seen with empty scoreboard");
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_err_count", int'(err_count), mon_e.err);
        chk("sb_pass", int'(pass), mon_e.pass);
        chk("sb_signature", int'(signature), mon_e.sig);
        last_sig = int'(signature);
      end
    end
  end

  always @(negedge clk) if (busy) busy_cyc++;

  logic [4:0] sv[$];
  logic       sval[$];

  task automatic add_slot(input logic [4:0] v, input logic vl);
    sv.push_back(v);
    sval.push_back(vl);
  endtask

  task automatic clear_slots();
    sv.delete();
    sval.delete();
  endtask

  // Expected error count and signature from the accepted-vector timeline
  task automatic model(input int num, input logic i22, input logic i23,
                       output int e_err, output int e_sig);
    int         acc_at[$];
    int         cnt;
    logic [15:0] s;
    logic [1:0] g;
    logic       t22, t23, d22, d23;
    cnt = 0;
    for (int i = 0; i < sv.size(); i++)
      if (sval[i] && cnt < num) begin
        acc_at.push_back(i);
        cnt++;
      end
    e_err = cnt * (int'(i22) + int'(i23));
    s = 16'hFFFF;
    for (int j = 1; j <= sv.size() + L23; j++) begin
      t22 = 1'b0; t23 = 1'b0; d22 = 1'b0; d23 = 1'b0;
      foreach (acc_at[k]) begin
        g = gold(sv[acc_at[k]]);
        if (acc_at[k] + 1 + L22 == j) begin t22 = 1'b1; d22 = g[1] ^ i22; end
        if (acc_at[k] + 1 + L23 == j) begin t23 = 1'b1; d23 = g[0] ^ i23; end
      end
      if (t22 || t23)
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, t23 & d23, t22 & d22};
    end
`ifdef C17_CHK_MISR_EN
    e_sig = int'(s);
`else
    e_sig = 0;
`endif
  endtask

  task automatic do_run(input int num, input logic i22, input logic i23,
                        input int exp_busy, input int abort_at, input int restart_at);
    int   e_err, e_sig, cyc;
    exp_t e;
    model(num, i22, i23, e_err, e_sig);
    inv22 = i22;
    inv23 = i23;
    if (abort_at < 0) begin
      e.err = e_err; e.pass = (e_err == 0) ? 1 : 0; e.sig = e_sig;
      sbq.push_back(e);
    end
    @(negedge clk);
    busy_cyc = 0;
    done_cnt = 0;
    start = 1'b1;
    num_patterns = CW'(num);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < sv.size(); i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_signature", int'(signature), 0);
        vec_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("post_rst_idle_busy", int'(busy), 0);
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_err_count", int'(err_count), 0);
        vec_valid = 1'b0;
        inv22 = 1'b0;
        inv23 = 1'b0;
        return;
      end
      vec_in    = sv[i];
      vec_valid = sval[i];
      start     = (i == restart_at);
      if (i == restart_at) num_patterns = '0;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    start = 1'b0;
    #1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: no done within 200 cycles (num=%0d)", num);
    end
    if (num == 0) chk("zero_done_next_cycle", cyc, 0);
    @(negedge clk);
    #1;
    chk("busy_cycles", busy_cyc, exp_busy);
    chk("done_once", done_cnt, 1);
    inv22 = 1'b0;
    inv23 = 1'b0;
  endtask

  int sig1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_patterns = '0; vec_valid = 1'b0; vec_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_signature", int'(signature), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive run, then a repeat with a start pulse mid-run that must be ignored
    clear_slots();
    for (int i = 0; i < 32; i++) add_slot(5'(i), 1'b1);
    do_run(32, 1'b0, 1'b0, 32 + L23, -1, -1);
    sig1 = last_sig;
    do_run(32, 1'b0, 1'b0, 32 + L23, -1, 10);
`ifdef C17_CHK_MISR_EN
    chk("signature_repeatable", last_sig, sig1);
`endif

    // single vectors: 00000 -> {0,0}, 11111 -> {1,0}
    clear_slots();
    add_slot(5'b00000, 1'b1);
    add_slot(5'b11111, 1'b1);
    do_run(2, 1'b0, 1'b0, 2 + L23, -1, -1);
    clear_slots();
    add_slot(5'b00000, 1'b1);
    do_run(1, 1'b1, 1'b0, 1 + L23, -1, -1);
    clear_slots();
    add_slot(5'b11111, 1'b1);
    do_run(1, 1'b1, 1'b1, 1 + L23, -1, -1);

    // N22 inverted over all 32 vectors
    clear_slots();
    for (int i = 0; i < 32; i++) add_slot(5'(i), 1'b1);
    do_run(32, 1'b1, 1'b0, 32 + L23, -1, -1);

    // bubbles: 8 vectors on alternate slots, both outputs inverted
    clear_slots();
    for (int i = 0; i < 16; i++) add_slot(5'(i * 3 + 1), (i % 2) == 0);
    do_run(8, 1'b1, 1'b1, 15 + L23, -1, -1);

    // vectors beyond num_patterns are ignored
    clear_slots();
    for (int i = 0; i < 6; i++) add_slot(5'(i * 5 + 2), 1'b1);
    do_run(4, 1'b1, 1'b0, 4 + L23, -1, -1);

    // zero-length run
    clear_slots();
    do_run(0, 1'b0, 1'b0, 0, -1, -1);

    // reset mid-run, then a normal run to confirm recovery
    clear_slots();
    for (int i = 0; i < 32; i++) add_slot(5'(31 - i), 1'b1);
    do_run(32, 1'b1, 1'b0, 0, 10, -1);
    clear_slots();
    add_slot(5'b10101, 1'b1);
    add_slot(5'b01010, 1'b1);
    do_run(2, 1'b0, 1'b0, 2 + L23, -1, -1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
